// File: rtl/l2_arbiter.sv
// l2_arbiter: grants the shared L2 port to the I-cache or D-cache miss path.
// D-cache wins by default; a saturating streak counter hands the port to a
// waiting I-cache after D_STREAK_MAX consecutive D grants.
//
// state  | meaning
// IDLE   | no L2 transaction; arbitrate pending requests
// BUSY_I | L2 transaction issued on behalf of the I-cache
// BUSY_D | L2 transaction issued on behalf of the D-cache
module l2_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int D_STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic                  i_mem_resp,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic                  d_mem_resp,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  l2_mem_read,
  output logic                  l2_mem_write,
  output logic [ADDR_WIDTH-1:0] l2_mem_address,
  output logic [LINE_WIDTH-1:0] l2_mem_wdata,
  input  logic [LINE_WIDTH-1:0] l2_mem_rdata,
  input  logic                  l2_mem_resp
);

  localparam int SW = $clog2(D_STREAK_MAX + 1) + 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e                state_q;
  logic                  rd_q, wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  i_pend, d_pend, d_win, i_win;

  // Arbitration decision and next starvation count, evaluated every cycle
  // but only consumed while IDLE.
  always_comb begin
    i_pend   = i_mem_read;
    d_pend   = d_mem_read | d_mem_write;
    d_win    = d_pend & (~i_pend | (streak_q < STREAK_MAX));
    i_win    = i_pend & ~d_win;
    streak_d = streak_q;
    if (d_win) begin
      if (i_pend) begin
        if (streak_q < STREAK_MAX) streak_d = streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end else if (i_win) begin
      streak_d = '0;
    end
  end

  // Grant FSM: capture the winner in IDLE, hold the L2 request until resp.
  // The L2 side cannot be aborted, so a client dropping its request only
  // suppresses its resp; the registered command stays up until l2_mem_resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      streak_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          streak_q <= streak_d;
          if (d_win) begin
            state_q <= BUSY_D;
            rd_q    <= d_mem_read;
            wr_q    <= d_mem_write;
            addr_q  <= d_mem_address;
            if (d_mem_write) wdata_q <= d_mem_wdata;
          end else if (i_win) begin
            state_q <= BUSY_I;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= i_mem_address;
          end
        end
        BUSY_I, BUSY_D: begin
          if (l2_mem_resp) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency response routing back to the granted, still-requesting client.
  always_comb begin
    i_mem_resp     = (state_q == BUSY_I) & l2_mem_resp & i_mem_read;
    d_mem_resp     = (state_q == BUSY_D) & l2_mem_resp & (d_mem_read | d_mem_write);
    i_mem_rdata    = l2_mem_rdata;
    d_mem_rdata    = l2_mem_rdata;
    l2_mem_read    = rd_q;
    l2_mem_write   = wr_q;
    l2_mem_address = addr_q;
    l2_mem_wdata   = wdata_q;
  end

endmodule
